// File: rtl/cond_ctrl.sv
// Condition-execute controller: gates reg/mem/pc writes on cond_i vs the NZCV register it owns.
// condex_o is combinational; gated outputs and undef_o land 1 cycle after accept. Stall/flush load bubbles.
// Optional macro COND_STATS_EN adds squash_cnt_o, a saturating count of accepted condition failures.
module cond_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid_i,
  input  logic       stall_i,
  input  logic       flush_i,
  input  logic [3:0] cond_i,
  input  logic [1:0] flagw_i,
  input  logic [3:0] alu_flags_i,
  input  logic       regw_i,
  input  logic       memw_i,
  input  logic       pcs_i,
  output logic       regw_o,
  output logic       memw_o,
  output logic       pcs_o,
  output logic       condex_o,
  output logic [3:0] flags_o,
  output logic       undef_o
`ifdef COND_STATS_EN
  ,
  output logic [15:0] squash_cnt_o
`endif
);

  logic n, z, c, v;
  logic cond_true;
  logic acc;
  logic upd;

  assign {n, z, c, v} = flags_o;

  // Evaluated against the committed flags so a same-cycle ALU result cannot gate itself.
  always_comb begin
    cond_true = 1'b0;
    case (cond_i)
      4'b0000: cond_true = z;
      4'b0001: cond_true = ~z;
      4'b0010: cond_true = c;
      4'b0011: cond_true = ~c;
      4'b0100: cond_true = n;
      4'b0101: cond_true = ~n;
      4'b0110: cond_true = v;
      4'b0111: cond_true = ~v;
      4'b1000: cond_true = c & ~z;
      4'b1001: cond_true = ~(c & ~z);
      4'b1010: cond_true = (n == v);
      4'b1011: cond_true = (n != v);
      4'b1100: cond_true = ~z & (n == v);
      4'b1101: cond_true = ~(~z & (n == v));
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign acc      = valid_i & ~stall_i & ~flush_i;
  assign condex_o = valid_i & cond_true;
  assign upd      = acc & condex_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_o <= 4'b0000;
    end else if (upd) begin
      if (flagw_i[1]) flags_o[3:2] <= alu_flags_i[3:2];
      if (flagw_i[0]) flags_o[1:0] <= alu_flags_i[1:0];
    end
  end

  // Reloaded every edge, so a stalled instruction can never produce a repeated write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regw_o  <= 1'b0;
      memw_o  <= 1'b0;
      pcs_o   <= 1'b0;
      undef_o <= 1'b0;
    end else begin
      regw_o  <= upd & regw_i;
      memw_o  <= upd & memw_i;
      pcs_o   <= upd & pcs_i;
      undef_o <= acc & (cond_i == 4'b1111);
    end
  end

`ifdef COND_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      squash_cnt_o <= 16'h0000;
    end else if (acc && !condex_o && (squash_cnt_o != 16'hFFFF)) begin
      squash_cnt_o <= squash_cnt_o + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_cond_ctrl.sv
// Bench for cond_ctrl: directed scenarios plus random traffic against an NZCV reference model.
module tb_cond_ctrl;

  logic       clk;
  logic       reset_n;
  logic       valid_i, stall_i, flush_i;
  logic [3:0] cond_i;
  logic [1:0] flagw_i;
  logic [3:0] alu_flags_i;
  logic       regw_i, memw_i, pcs_i;
  logic       regw_o, memw_o, pcs_o, condex_o, undef_o;
  logic [3:0] flags_o;
`ifdef COND_STATS_EN
  logic [15:0] squash_cnt_o;
`endif

  int checks = 0;
  int fails  = 0;

  bit [3:0]  m_flags;
  bit        m_regw, m_memw, m_pcs, m_undef, m_condex;
  bit [15:0] m_cnt;

  cond_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .cond_i(cond_i), .flagw_i(flagw_i), .alu_flags_i(alu_flags_i),
    .regw_i(regw_i), .memw_i(memw_i), .pcs_i(pcs_i),
    .regw_o(regw_o), .memw_o(memw_o), .pcs_o(pcs_o),
    .condex_o(condex_o), .flags_o(flags_o), .undef_o(undef_o)
`ifdef COND_STATS_EN
    , .squash_cnt_o(squash_cnt_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Conditions come in pairs: even code is the predicate, odd code its inverse.
  function automatic bit cond_eval(input bit [3:0] cnd, input bit [3:0] f);
    bit fn, fz, fc, fv, base;
    {fn, fz, fc, fv} = f;
    case (cnd[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc && !fz;
      3'd5: base = (fn == fv);
      3'd6: base = !fz && (fn == fv);
      default: base = 1'b1;
    endcase
    return cnd[0] ? !base : base;
  endfunction

  function automatic void model_reset();
    m_flags = 4'b0; m_regw = 0; m_memw = 0; m_pcs = 0; m_undef = 0; m_cnt = 16'h0;
  endfunction

  // Predicts the post-edge state from the inputs currently applied.
  function automatic void model_step();
    bit acc, upd;
    acc      = valid_i && !stall_i && !flush_i;
    m_condex = valid_i && cond_eval(cond_i, m_flags);
    upd      = acc && m_condex;
    m_regw   = upd && regw_i;
    m_memw   = upd && memw_i;
    m_pcs    = upd && pcs_i;
    m_undef  = acc && (cond_i == 4'hF);
    if (upd && flagw_i[1]) m_flags[3:2] = alu_flags_i[3:2];
    if (upd && flagw_i[0]) m_flags[1:0] = alu_flags_i[1:0];
    if (acc && !m_condex && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
  endfunction

  task automatic apply(input bit v, input bit s, input bit f, input bit [3:0] cnd,
                       input bit [1:0] fw, input bit [3:0] alu,
                       input bit rw, input bit mw, input bit ps);
    valid_i = v; stall_i = s; flush_i = f; cond_i = cnd; flagw_i = fw;
    alu_flags_i = alu; regw_i = rw; memw_i = mw; pcs_i = ps;
    #1;
    model_step();
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(0, 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({regw_o, memw_o, pcs_o, undef_o, flags_o} !== 8'h00) begin
        fails++; $display("FAIL reset_outputs: got %b, want 00000000", {regw_o, memw_o, pcs_o, undef_o, flags_o});
      end
`ifdef COND_STATS_EN
      checks++;
      if (squash_cnt_o !== 16'h0) begin
        fails++; $display("FAIL reset_cnt: got %h, want 0000", squash_cnt_o);
      end
`endif
      edge_step();
    end
    reset_n = 1'b1;
  endtask

  task automatic test_first_fail();
    apply(1, 0, 0, 4'b0000, 2'b00, 4'h0, 1, 0, 0);
    checks++;
    if (condex_o !== 1'b0) begin fails++; $display("FAIL first_condex: got %b, want 0", condex_o); end
    edge_step();
    checks++;
    if (regw_o !== 1'b0) begin fails++; $display("FAIL first_regw: got %b, want 0", regw_o); end
`ifdef COND_STATS_EN
    checks++;
    if (squash_cnt_o !== 16'h1) begin fails++; $display("FAIL first_cnt: got %h, want 0001", squash_cnt_o); end
`endif
  endtask

  task automatic test_back_to_back();
    apply(1, 0, 0, 4'b1110, 2'b11, 4'b0100, 1, 0, 0);
    checks++;
    if (condex_o !== 1'b1) begin fails++; $display("FAIL b2b_al_condex: got %b, want 1", condex_o); end
    edge_step();
    checks++;
    if (flags_o !== 4'b0100 || regw_o !== 1'b1) begin
      fails++; $display("FAIL b2b_write: flags %b regw %b, want 0100 1", flags_o, regw_o);
    end
    apply(1, 0, 0, 4'b0000, 2'b00, 4'h0, 0, 0, 0);
    checks++;
    if (condex_o !== 1'b1) begin fails++; $display("FAIL b2b_eq_condex: got %b, want 1", condex_o); end
    edge_step();
  endtask

  task automatic test_partial_flags();
    apply(1, 0, 0, 4'b1110, 2'b11, 4'b1001, 0, 0, 0);
    edge_step();
    apply(1, 0, 0, 4'b1110, 2'b01, 4'b0110, 0, 0, 0);
    edge_step();
    checks++;
    if (flags_o !== 4'b1010) begin fails++; $display("FAIL partial_flags: got %b, want 1010", flags_o); end
    apply(1, 0, 0, 4'b1010, 2'b11, 4'b0000, 1, 0, 0);
    checks++;
    if (condex_o !== 1'b0) begin fails++; $display("FAIL ge_condex: got %b, want 0", condex_o); end
    edge_step();
    checks++;
    if (flags_o !== 4'b1010 || regw_o !== 1'b0) begin
      fails++; $display("FAIL ge_hold: flags %b regw %b, want 1010 0", flags_o, regw_o);
    end
  endtask

  task automatic test_stall_flush();
    bit [3:0]  f0;
    bit [15:0] c0;
    f0 = m_flags; c0 = m_cnt;
    apply(1, 1, 1, 4'b1110, 2'b11, ~f0, 0, 1, 0);
    edge_step();
    checks++;
    if (memw_o !== 1'b0 || flags_o !== f0) begin
      fails++; $display("FAIL stall_flush: memw %b flags %b, want 0 %b", memw_o, flags_o, f0);
    end
    apply(1, 1, 0, 4'b1111, 2'b11, ~f0, 1, 1, 1);
    edge_step();
    apply(1, 0, 1, 4'b1110, 2'b11, ~f0, 1, 1, 1);
    edge_step();
    checks++;
    if ({regw_o, memw_o, pcs_o, undef_o} !== 4'b0000 || flags_o !== f0) begin
      fails++; $display("FAIL bubble: outs %b flags %b, want 0000 %b", {regw_o, memw_o, pcs_o, undef_o}, flags_o, f0);
    end
`ifdef COND_STATS_EN
    checks++;
    if (squash_cnt_o !== c0) begin fails++; $display("FAIL stall_cnt: got %h, want %h", squash_cnt_o, c0); end
`endif
  endtask

  task automatic test_undef();
    bit [3:0] f0;
    f0 = m_flags;
    apply(1, 0, 0, 4'b1111, 2'b11, ~f0, 1, 1, 1);
    checks++;
    if (condex_o !== 1'b0) begin fails++; $display("FAIL undef_condex: got %b, want 0", condex_o); end
    edge_step();
    checks++;
    if (undef_o !== 1'b1 || regw_o !== 1'b0 || flags_o !== f0) begin
      fails++; $display("FAIL undef_pulse: undef %b regw %b flags %b, want 1 0 %b", undef_o, regw_o, flags_o, f0);
    end
    apply(0, 0, 0, 4'b1111, 2'b00, 4'h0, 1, 0, 0);
    edge_step();
    checks++;
    if (undef_o !== 1'b0) begin fails++; $display("FAIL undef_width: got %b, want 0", undef_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      apply($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, $urandom_range(0, 19) < 3,
            4'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (condex_o !== m_condex) begin
        fails++; $display("FAIL rand_condex[%0d]: got %b, want %b", i, condex_o, m_condex);
      end
      edge_step();
      checks++;
      if ({regw_o, memw_o, pcs_o, undef_o, flags_o} !== {m_regw, m_memw, m_pcs, m_undef, m_flags}) begin
        fails++; $display("FAIL rand_state[%0d]: got %b, want %b", i,
                          {regw_o, memw_o, pcs_o, undef_o, flags_o}, {m_regw, m_memw, m_pcs, m_undef, m_flags});
      end
`ifdef COND_STATS_EN
      checks++;
      if (squash_cnt_o !== m_cnt) begin
        fails++; $display("FAIL rand_cnt[%0d]: got %h, want %h", i, squash_cnt_o, m_cnt);
      end
`endif
    end
  endtask

`ifdef COND_STATS_EN
  task automatic test_saturation();
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFE; i++) begin
      apply(1, 0, 0, 4'b1111, 2'b00, 4'h0, 0, 0, 0);
      edge_step();
    end
    checks++;
    if (squash_cnt_o !== 16'hFFFE) begin fails++; $display("FAIL sat_pre: got %h, want fffe", squash_cnt_o); end
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 4'b1111, 2'b00, 4'h0, 0, 0, 0);
      edge_step();
      checks++;
      if (squash_cnt_o !== 16'hFFFF) begin fails++; $display("FAIL sat_hold[%0d]: got %h, want ffff", i, squash_cnt_o); end
    end
  endtask
`endif

  task automatic test_async_reset();
    apply(1, 0, 0, 4'b1110, 2'b11, 4'b1111, 1, 1, 1);
    edge_step();
    checks++;
    if ({regw_o, memw_o, pcs_o, flags_o} !== 7'b1111111) begin
      fails++; $display("FAIL pre_reset: got %b, want 1111111", {regw_o, memw_o, pcs_o, flags_o});
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({regw_o, memw_o, pcs_o, undef_o, flags_o} !== 8'h00) begin
      fails++; $display("FAIL async_reset: got %b, want 00000000", {regw_o, memw_o, pcs_o, undef_o, flags_o});
    end
`ifdef COND_STATS_EN
    checks++;
    if (squash_cnt_o !== 16'h0) begin fails++; $display("FAIL async_cnt: got %h, want 0000", squash_cnt_o); end
`endif
    edge_step();
    checks++;
    if ({regw_o, memw_o, pcs_o, undef_o, flags_o} !== 8'h00) begin
      fails++; $display("FAIL reset_hold: got %b, want 00000000", {regw_o, memw_o, pcs_o, undef_o, flags_o});
    end
    apply(0, 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0);
    reset_n = 1'b1;
    edge_step();
    checks++;
    if (flags_o !== 4'b0000) begin fails++; $display("FAIL post_reset_flags: got %b, want 0000", flags_o); end
  endtask

  initial begin
    test_reset();
    test_first_fail();
    test_back_to_back();
    test_partial_flags();
    test_stall_flush();
    test_undef();
    test_random();
`ifdef COND_STATS_EN
    test_saturation();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cond_ctrl.md
COND_CTRL -- requirements
Module: cond_ctrl

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset: clk and reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset; assertion clears all state immediately, release is synchronous to clk.
REQ-004 valid_i  input  1  execute-stage instruction present this cycle.
REQ-005 stall_i  input  1  pipeline stall; the instruction is not accepted this cycle.
REQ-006 flush_i  input  1  kill the execute-stage instruction; dominates stall_i.
REQ-007 cond_i  input  4  condition field of the instruction.
REQ-008 flagw_i  input  2  flag write enables; bit1 = N,Z, bit0 = C,V.
REQ-009 alu_flags_i  input  4  {N,Z,C,V} produced by the ALU for this instruction.
REQ-010 regw_i, memw_i, pcs_i  input  1 each  unconditional register-write, memory-write and PC-source requests.
REQ-011 regw_o, memw_o, pcs_o  output  1 each  registered, condition-gated versions of the requests.
REQ-012 condex_o  output  1  combinational condition result for the current instruction.
REQ-013 flags_o  output  4  architectural {N,Z,C,V} register.
REQ-014 undef_o  output  1  registered one-cycle pulse for an accepted instruction with cond_i = 4'b1111.
REQ-015 squash_cnt_o  output  16  count of accepted instructions that failed their condition (present only under COND_STATS_EN).

Function
REQ-016 Accept condition SHALL be acc = valid_i & ~stall_i & ~flush_i.
REQ-017 condex_o SHALL evaluate cond_i against flags_o (pre-update value), never against alu_flags_i: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~(C&~Z); 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 ~(~Z&(N==V)); 1110 1; 1111 0.
REQ-018 condex_o SHALL be 0 whenever valid_i = 0.
REQ-019 On a clk edge with acc & condex_o: flags_o[3:2] <= alu_flags_i[3:2] if flagw_i[1]; flags_o[1:0] <= alu_flags_i[1:0] if flagw_i[0]; unselected fields hold.
REQ-020 Flags SHALL hold on every edge where acc & condex_o is false (including stall, flush, failed condition).
REQ-021 regw_o/memw_o/pcs_o SHALL be loaded each edge with acc & condex_o & the matching request input; latency exactly 1 cycle.
REQ-022 During stall_i or flush_i the output registers SHALL load 0 (bubble); no output ever repeats for a stalled instruction.
REQ-023 undef_o SHALL be loaded with acc & (cond_i == 4'b1111); such an instruction writes no flags and asserts no gated output.
REQ-024 Back-to-back instructions: an instruction accepted in cycle n+1 SHALL see flags written by the instruction accepted in cycle n.

Reset
REQ-025 While reset_n = 0: flags_o = 4'b0000, regw_o = memw_o = pcs_o = 0, undef_o = 0, squash_cnt_o = 0.
REQ-026 Reset asserted mid-instruction SHALL discard that instruction; no flag or output update survives it.

Configuration
REQ-027 Macro COND_STATS_EN: when defined, squash_cnt_o exists and increments by 1 on each edge with acc & ~condex_o (including cond 1111), saturating at 16'hFFFF; when undefined, the port and counter are absent and all other behaviour is identical.

Verification
REQ-028 Reset then valid_i=1, cond_i=0000, flags 0000 -> condex_o=0, regw_o=0 next cycle, squash_cnt_o=1 (COND_STATS_EN).
REQ-029 cond_i=1110, flagw_i=11, alu_flags_i=0100, regw_i=1 -> next cycle flags_o=0100, regw_o=1; following cond_i=0000 instruction -> condex_o=1.
REQ-030 flags_o=1001, flagw_i=01, alu_flags_i=0110 accepted with cond 1110 -> flags_o=1010 (N,Z held, C,V updated); then cond_i=1010 -> condex_o=0.
REQ-031 stall_i=1 and flush_i=1 with cond 1110, memw_i=1, flagw_i=11 -> memw_o=0, flags unchanged, counter unchanged.
REQ-032 cond_i=1111 accepted with regw_i=1 -> undef_o=1 for exactly one cycle, regw_o=0, flags unchanged.
REQ-033 Counter preloaded to 16'hFFFE via 2 failed-condition instructions after forcing -> reaches 16'hFFFF and stays on further failures; reset_n pulse mid-cycle -> all outputs 0 immediately.
